mem_op_seq: RTL

Parametrised memory-to-memory operation sequencer. It holds a local register-file RAM and runs one operation per `start` pulse: read operand A, read operand B, execute, write the result back. A `start`/`busy`/`done` handshake replaces the free-running counter sequencing. It sits between host control logic and datapath users, and generalises width, depth and operation set (four modes instead of two).

---
 rtl/mem_op_pkg.sv | 21 ++
 rtl/mem_op_seq_op_ram.sv | 42 ++++
 rtl/mem_op_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_op_pkg.sv
// rtl/mem_op_pkg.sv - shared types for the memory operation sequencer
// Purpose: operation-mode and FSM-state enumerations used by mem_op_seq.
// Ports: none (package).
package mem_op_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WR   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_op_seq_op_ram.sv
// rtl/mem_op_seq_op_ram.sv - register-file storage for mem_op_seq
// Purpose: DEPTH x WIDTH register array, one synchronous write port,
//          two asynchronous read ports, all words cleared by reset.
// Ports:
//   clk, rst            clock, async active-high reset
//   we, waddr, wdata    write port (caller muxes host load / writeback)
//   op_raddr, op_rdata  operand read port
//   host_raddr, host_rdata  host observation read port
module op_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] op_raddr,
  output logic [WIDTH-1:0]  op_rdata,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic [WIDTH-1:0]  host_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads are combinational, so a write shows up only after its edge.
  assign op_rdata   = mem[op_raddr];
  assign host_rdata = mem[host_raddr];

endmodule

// File: rtl/mem_op_seq.sv
// rtl/mem_op_seq.sv - start/busy/done memory-to-memory operation sequencer
// Purpose: per start pulse, read A, read B, compute AND/OR/XOR/ADD, write
//          the result back into the local register file.
// Ports:
//   clk, rst                    clock, async active-high reset
//   start, mode                 operation request and select (IDLE only)
//   a_addr, b_addr, c_addr      operand / destination addresses
//   ld_en, ld_addr, ld_data     host write (IDLE only)
//   rd_addr, rd_data            host combinational read
//   busy, done, result          status and last computed value
module mem_op_seq
  import mem_op_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result
);

  state_e            state, state_nxt;
  mode_e             mode_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q, c_addr_q;
  logic [WIDTH-1:0]  a_q, b_q, result_q;
  logic              done_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [ADDR_W-1:0] op_raddr;
  logic [WIDTH-1:0]  op_rdata;
  logic [WIDTH-1:0]  alu_out;

  op_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .we         (ram_we),
    .waddr      (ram_waddr),
    .wdata      (ram_wdata),
    .op_raddr   (op_raddr),
    .op_rdata   (op_rdata),
    .host_raddr (rd_addr),
    .host_rdata (rd_data)
  );

  // ADD wraps modulo 2^WIDTH; the carry is simply not kept.
  always_comb begin
    alu_out = '0;
    case (mode_q)
      OP_AND:  alu_out = a_q & b_q;
      OP_OR:   alu_out = a_q | b_q;
      OP_XOR:  alu_out = a_q ^ b_q;
      OP_ADD:  alu_out = a_q + b_q;
      default: alu_out = '0;
    endcase
  end

  // Next state plus the single RAM write port: host load owns it in IDLE,
  // writeback owns it in WR, so the two can never collide.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_waddr = ld_addr;
    ram_wdata = ld_data;
    op_raddr  = a_addr_q;
    case (state)
      S_IDLE: begin
        ram_we = ld_en;
        if (start) state_nxt = S_RD_A;
      end
      S_RD_A: state_nxt = S_RD_B;
      S_RD_B: begin
        op_raddr  = b_addr_q;
        state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_WR;
      S_WR: begin
        ram_we    = 1'b1;
        ram_waddr = c_addr_q;
        ram_wdata = result_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= OP_AND;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == S_WR);
      if (state == S_IDLE && start) begin
        mode_q   <= mode_e'(mode);
        a_addr_q <= a_addr;
        b_addr_q <= b_addr;
        c_addr_q <= c_addr;
      end
      // Operands are captured before WR, so aliased destinations are safe.
      if (state == S_RD_A) a_q <= op_rdata;
      if (state == S_RD_B) b_q <= op_rdata;
      if (state == S_EXEC) result_q <= alu_out;
    end
  end

  assign busy   = (state != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
